rand_pick: RTL and testbench



---
 rtl/rand_pick_pkg.sv | 26 ++
 rtl/rand_pick.sv | 120 ++++++++++++
 tb/tb_rand_pick.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rand_pick_pkg.sv
// Shared types and helpers for the rand_pick uniform value picker.
// Holds the FSM state encoding and the PRNG XOR-fold function.
package rand_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SAMPLE = 1'b1
  } state_t;

  localparam int FOLD_W = 32;

  // XOR the two low k-bit slices of rnd together; bits at and above k are zero.
  function automatic logic [FOLD_W-1:0] fold_k(input logic [2*FOLD_W-1:0] rnd, input int k);
    logic [FOLD_W-1:0] f;
    f = '0;
    for (int i = 0; i < FOLD_W; i++) begin
      if (i < k) begin
        f[i] = rnd[i] ^ rnd[i+k];
      end else begin
        f[i] = 1'b0;
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/rand_pick.sv
// Rejection-sampling picker: turns a free-running PRNG word into one value in
// [0, RANGE) per request, optionally never repeating, with a bounded fallback.
module rand_pick
  import rand_pkg::*;
#(
  parameter int N         = 24,
  parameter int K         = 4,
  parameter int RANGE     = 10,
  parameter int NO_REPEAT = 1,
  parameter int MAX_TRIES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] rnd_i,
  input  logic         req_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [K-1:0] value_o,
  output logic         fallback_o
);

  localparam int TW = $clog2(MAX_TRIES) + 1;
  // Range compares run at K+1 bits so RANGE = 2**K is representable.
  localparam logic [K:0]    RANGE_K1 = (K+1)'(RANGE);
  localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

  state_t        state_r, state_nxt_s;
  logic [TW-1:0] tries_r, tries_nxt_s;
  logic [K-1:0]  last_r, last_nxt_s;
  logic          have_last_r, have_last_nxt_s;
  logic [K-1:0]  value_nxt_s;
  logic          valid_nxt_s, fallback_nxt_s;

  logic [K-1:0]  cand_s;
  logic [K:0]    last_inc_s;
  logic [K-1:0]  fb_val_s;
  logic          in_range_s, repeat_s, accept_s;

  assign busy_o = (state_r == SAMPLE);

  // Candidate extraction, accept decision and fallback value.
  always_comb begin
    cand_s     = K'(fold_k((2*FOLD_W)'(rnd_i), K));
    in_range_s = ({1'b0, cand_s} < RANGE_K1);
    repeat_s   = (NO_REPEAT != 0) && have_last_r && (cand_s == last_r);
    accept_s   = in_range_s && !repeat_s;
    last_inc_s = {1'b0, last_r} + (K+1)'(1);
    if (!have_last_r) begin
      fb_val_s = '0;
    end else if (last_inc_s == RANGE_K1) begin
      fb_val_s = '0;
    end else begin
      fb_val_s = last_inc_s[K-1:0];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s     = state_r;
    tries_nxt_s     = tries_r;
    last_nxt_s      = last_r;
    have_last_nxt_s = have_last_r;
    value_nxt_s     = value_o;
    valid_nxt_s     = 1'b0;
    fallback_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_i) begin
          state_nxt_s = SAMPLE;
          tries_nxt_s = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SAMPLE: begin
        if (accept_s) begin
          value_nxt_s     = cand_s;
          last_nxt_s      = cand_s;
          have_last_nxt_s = 1'b1;
          valid_nxt_s     = 1'b1;
          state_nxt_s     = IDLE;
        end else if (tries_r == LAST_TRY) begin
          value_nxt_s     = fb_val_s;
          last_nxt_s      = fb_val_s;
          have_last_nxt_s = 1'b1;
          valid_nxt_s     = 1'b1;
          fallback_nxt_s  = 1'b1;
          state_nxt_s     = IDLE;
        end else begin
          tries_nxt_s = tries_r + TW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, history and registered outputs; reset also clears history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      tries_r     <= '0;
      last_r      <= '0;
      have_last_r <= 1'b0;
      value_o     <= '0;
      valid_o     <= 1'b0;
      fallback_o  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      tries_r     <= tries_nxt_s;
      last_r      <= last_nxt_s;
      have_last_r <= have_last_nxt_s;
      value_o     <= value_nxt_s;
      valid_o     <= valid_nxt_s;
      fallback_o  <= fallback_nxt_s;
    end
  end

endmodule

// File: tb/tb_rand_pick.sv
// Scoreboard bench for rand_pick: one NO_REPEAT=1 instance and one NO_REPEAT=0
// instance; expectations are queued at request time and popped on valid_o.
module tb_rand_pick;

  typedef struct packed {
    logic [3:0] v;
    logic       f;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [23:0] rnd;
  logic        req, req2;
  logic        busy, valid, fb;
  logic [3:0]  value;
  logic        busy2, valid2, fb2;
  logic [3:0]  value2;

  exp_t q1[$];
  exp_t q2[$];
  int   passed;
  int   total;
  int   vcnt;
  logic mon_en;

  rand_pick #(.N(24), .K(4), .RANGE(10), .NO_REPEAT(1), .MAX_TRIES(16)) dut (
    .clk(clk), .reset(reset), .rnd_i(rnd), .req_i(req),
    .busy_o(busy), .valid_o(valid), .value_o(value), .fallback_o(fb)
  );

  rand_pick #(.N(24), .K(4), .RANGE(10), .NO_REPEAT(0), .MAX_TRIES(16)) dut_nr (
    .clk(clk), .reset(reset), .rnd_i(rnd), .req_i(req2),
    .busy_o(busy2), .valid_o(valid2), .value_o(value2), .fallback_o(fb2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q1.size() == 0 && q2.size() == 0 && !busy && !busy2) break;
      tick();
    end
    check_eq("drain", 32'(q1.size() + q2.size()), 32'd0);
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid === 1'b1) begin
        vcnt++;
        check_eq("q1_nonempty", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          exp_t e;
          e = q1.pop_front();
          check_eq("value", 32'(value), 32'(e.v));
          check_eq("fallback", 32'(fb), 32'(e.f));
        end
      end else begin
        check_eq("fb_without_valid", 32'(fb), 32'd0);
      end
      if (valid2 === 1'b1) begin
        check_eq("q2_nonempty", 32'(q2.size() != 0), 32'd1);
        if (q2.size() != 0) begin
          exp_t e2;
          e2 = q2.pop_front();
          check_eq("nr_value", 32'(value2), 32'(e2.v));
          check_eq("nr_fallback", 32'(fb2), 32'(e2.f));
        end
      end
    end
  end

  initial begin
    int v0;
    passed = 0;
    total  = 0;
    vcnt   = 0;
    mon_en = 1'b0;
    reset  = 1'b1;
    req    = 1'b1;
    req2   = 1'b1;
    rnd    = 24'h000000;

    for (int i = 0; i < 2; i++) begin
      rnd = 24'($urandom);
      tick();
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_value", 32'(value), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_fb", 32'(fb), 32'd0);
      check_eq("rst_nr_valid", 32'(valid2), 32'd0);
    end
    reset  = 1'b0;
    req    = 1'b0;
    req2   = 1'b0;
    mon_en = 1'b1;
    tick();
    check_eq("idle_after_reset", 32'(busy), 32'd0);

    // Direct hit: 5 ^ 3 = 6.
    rnd = 24'h000035;
    q1.push_back('{v: 4'd6, f: 1'b0});
    pulse_req();
    check_eq("hit_busy", 32'(busy), 32'd1);
    tick();
    check_eq("hit_latency", 32'(valid), 32'd1);
    check_eq("hit_busy_done", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check_eq("hit_hold", 32'(value), 32'd6);
    check_eq("hit_pulse_once", 32'(valid), 32'd0);

    // Range rejection: cand 15 twice, then cand 3.
    rnd = 24'h0000F0;
    q1.push_back('{v: 4'd3, f: 1'b0});
    pulse_req();
    tick();
    tick();
    check_eq("range_reject", 32'(valid), 32'd0);
    rnd = 24'h000012;
    tick();
    check_eq("range_latency", 32'(valid), 32'd1);
    drain();

    // No-repeat: 3 equals last, rejected; 7 accepted.
    rnd = 24'h000012;
    q1.push_back('{v: 4'd7, f: 1'b0});
    pulse_req();
    tick();
    check_eq("norep_reject", 32'(valid), 32'd0);
    rnd = 24'h000007;
    tick();
    check_eq("norep_accept", 32'(valid), 32'd1);
    drain();

    // NO_REPEAT=0 instance accepts 3 twice in a row.
    rnd = 24'h000012;
    for (int i = 0; i < 2; i++) begin
      q2.push_back('{v: 4'd3, f: 1'b0});
      req2 = 1'b1;
      tick();
      req2 = 1'b0;
      tick();
      check_eq("rep_accept_now", 32'(valid2), 32'd1);
      tick();
    end
    drain();

    // Fallback from last=7 gives 8 after 16 sample edges.
    rnd = 24'h0000F0;
    q1.push_back('{v: 4'd8, f: 1'b1});
    pulse_req();
    for (int i = 0; i < 15; i++) begin
      tick();
      check_eq("fb_early", 32'(valid), 32'd0);
    end
    tick();
    check_eq("fb_latency", 32'(valid), 32'd1);
    drain();

    // Seed last=9, then fallback wraps to 0.
    rnd = 24'h000009;
    q1.push_back('{v: 4'd9, f: 1'b0});
    pulse_req();
    drain();
    rnd = 24'h0000F0;
    q1.push_back('{v: 4'd0, f: 1'b1});
    pulse_req();
    drain();

    // Requests during SAMPLE are ignored.
    v0 = vcnt;
    rnd = 24'h0000F0;
    q1.push_back('{v: 4'd5, f: 1'b0});
    pulse_req();
    tick();
    pulse_req();
    tick();
    pulse_req();
    rnd = 24'h000005;
    tick();
    drain();
    for (int i = 0; i < 4; i++) tick();
    check_eq("busy_ignore_count", 32'(vcnt - v0), 32'd1);

    // Reset mid-SAMPLE aborts the request and clears history.
    v0 = vcnt;
    rnd = 24'h0000F0;
    pulse_req();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check_eq("abort_no_valid", 32'(vcnt - v0), 32'd0);
    rnd = 24'h000005;
    q1.push_back('{v: 4'd5, f: 1'b0});
    pulse_req();
    tick();
    check_eq("hist_cleared", 32'(valid), 32'd1);
    drain();

    // Continuous requests: a direct hit every two cycles.
    req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rnd = (i % 2 == 1) ? 24'h000002 : 24'h000001;
      q1.push_back('{v: (i % 2 == 1) ? 4'd2 : 4'd1, f: 1'b0});
      tick();
      check_eq("b2b_gap", 32'(valid), 32'd0);
      tick();
      check_eq("b2b_valid", 32'(valid), 32'd1);
    end
    req = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
